exc_request_ctrl: RTL and testbench
===================================

Name: exc_request_ctrl

Overview:
- Upstream source of the exception-control inputs of the single-cycle LEGv8 datapath: drives `Exc` and `EStatus[3:0]`, and consumes `ExcAck` and `ERet`.
- Collects three exception sources, latches each as pending, and prioritises them.
- Holds the request until the datapath acknowledges, then masks further requests until the handler executes ERET.

Parameters:
- IRQ_SYNC_STAGES, 2, number of flip-flops synchronising the asynchronous `irq` input (minimum 2).
- ACK_TIMEOUT, 16, REQ-state cycle limit before timeout (used only with `EXC_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  1  external interrupt; level-sensitive, asynchronous to `clk`.
- `inv_opcode`  in  1  one-cycle pulse from decode: invalid instruction.
- `dm_access`  in  1  data memory access this cycle (memRead | memWrite).
- `dm_addr_lo`  in  3  `DM_addr[2:0]` of the current access.
- `ExcAck`  in  1  datapath has taken the exception (ELR/ESR saved, PC redirected).
- `ERet`  in  1  ERET executing this cycle.
- `Exc`  out  1  exception request to the datapath.
- `EStatus`  out  4  cause code.
- `in_handler`  out  1  high while the handler runs.
- `timeout_err`  out  1  sticky acknowledge-timeout flag; present only with `EXC_TIMEOUT_EN`.

Behaviour:
- Reset (`reset`=0, asynchronous): state IDLE; all pending bits and the sync chain cleared; `Exc`=0, `EStatus`=4'b0000, `in_handler`=0, `timeout_err`=0.

Sources and pending bits (set at the clock edge of detection):
- `mis`: `dm_access`=1 and `dm_addr_lo`≠3'b000. Code 4'b0011.
- `inv`: `inv_opcode`=1. Code 4'b0010.
- `irq`: synchronised `irq`=1, sampled after IRQ_SYNC_STAGES edges. Code 4'b0001.
- Priority: `mis` > `inv` > `irq`.
- Pending bits are sticky until serviced. Sources are latched in every state, including HANDLER.
- If a source sets a bit on the same edge that clears it, set wins.

FSM (all outputs registered):
- IDLE: when any pending bit is set, latch the highest-priority code into `EStatus` and go to REQ.
  - `Exc`=1 from the cycle after the edge where the pending bit was set (`inv`/`mis`: 1-cycle latency; `irq`: IRQ_SYNC_STAGES+1).
- REQ: `Exc`=1, `EStatus` stable; a later, higher-priority arrival does NOT change `EStatus`.
  - `ExcAck`=1: clear the serviced pending bit, go to HANDLER; `Exc`=0 and `in_handler`=1 on the next cycle.
- HANDLER: `Exc`=0, `in_handler`=1, `EStatus` holds the last code.
  - `ERet`=1: go to IDLE with `in_handler`=0; any remaining pending bit issues a new request one cycle later.
- Ignored inputs:
  - `ExcAck` outside REQ.
  - `ERet` in IDLE or REQ.
  - `ERet` and `ExcAck` together in REQ: `ExcAck` is taken and `ERet` is ignored.
- Level `irq`: if still high after service, it re-pends. The handler must clear the device before ERET.
- Reset mid-request or mid-handler: immediate return to the reset state; pending events are lost.

Optional Feature:
- Macro: `EXC_TIMEOUT_EN`.
- With it defined:
  - A counter runs in REQ, cleared on entry to REQ.
  - If `ExcAck` has not arrived after ACK_TIMEOUT cycles, the controller drops the serviced pending bit, sets `timeout_err`=1 (sticky until reset), deasserts `Exc` and returns to IDLE.
  - `ExcAck` on the expiry cycle wins: normal path, no error.
- Without it: no counter and no `timeout_err` port; REQ waits indefinitely.

Test Plan:
- Reset release, all sources idle 20 cycles -> `Exc`=0, `EStatus`=0, `in_handler`=0 throughout.
- `inv_opcode` pulse at cycle 5, `ExcAck` at cycle 8, `ERet` at cycle 12 -> `Exc`=1 cycles 6-8 with `EStatus`=4'b0010; `in_handler`=1 cycles 9-12; 0 from cycle 13.
- `irq` rises at cycle 3 (IRQ_SYNC_STAGES=2) -> `Exc`=1 at cycle 6 with `EStatus`=4'b0001; `irq` still high after ERET -> new request 1 cycle after `in_handler` falls.
- `inv_opcode` and a misaligned access (`dm_access`=1, `dm_addr_lo`=3'b100) in the same cycle -> `EStatus`=4'b0011 first; after ERET, second request with 4'b0010.
- `inv_opcode` during HANDLER -> no `Exc` until ERET; then `Exc`=1 the cycle after `in_handler` falls, `EStatus`=4'b0010.
- With `EXC_TIMEOUT_EN` and ACK_TIMEOUT=16, no `ExcAck` -> `Exc` drops after 16 cycles and `timeout_err`=1 until reset; repeat with `ExcAck` on cycle 16 -> `timeout_err` stays 0.

Source files
------------

// File: rtl/exc_request_ctrl_if.sv
// Exception handshake between the request controller (master) and the
// datapath (slave): request + cause out, acknowledge + ERET back.
interface exc_request_ctrl_if;
  logic       Exc;
  logic [3:0] EStatus;
  logic       in_handler;
  logic       ExcAck;
  logic       ERet;

  modport master (output Exc, EStatus, in_handler, input ExcAck, ERet);
  modport slave  (input Exc, EStatus, in_handler, output ExcAck, ERet);
endinterface

// File: rtl/exc_request_ctrl.sv
// Exception request controller for the single-cycle LEGv8 datapath: latches
// mis/inv/irq causes, raises Exc with a prioritised EStatus, waits for ExcAck,
// then masks requests until ERET. Define EXC_TIMEOUT_EN for the ack timeout.
module exc_request_ctrl #(
  parameter int IRQ_SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq,
  input  logic       inv_opcode,
  input  logic       dm_access,
  input  logic [2:0] dm_addr_lo,
`ifdef EXC_TIMEOUT_EN
  output logic       timeout_err,
`endif
  exc_request_ctrl_if.master ex
);

  if (IRQ_SYNC_STAGES < 2) begin : g_bad_sync
    $error("IRQ_SYNC_STAGES must be at least 2");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

  state_t                     state, state_nxt;
  logic [IRQ_SYNC_STAGES-1:0] sync;
  // pending/source bit order: [2]=mis, [1]=inv, [0]=irq, so code = index+1
  logic [2:0]                 pend, pend_nxt, src, clr;
  logic [3:0]                 est, est_nxt;
  logic                       exc_q, hnd_q;

`ifdef EXC_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          terr, terr_nxt;
`endif

  function automatic logic [3:0] prio(input logic [2:0] p);
    if (p[2])      return 4'b0011;
    else if (p[1]) return 4'b0010;
    else if (p[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  function automatic logic [2:0] code_bit(input logic [3:0] code);
    case (code)
      4'b0011: return 3'b100;
      4'b0010: return 3'b010;
      4'b0001: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[IRQ_SYNC_STAGES-2:0], irq};
  end

  // IDLE looks at pend|src so a cause detected on this edge requests at once
  always_comb begin
    src       = {dm_access && (dm_addr_lo != 3'b000), inv_opcode, sync[IRQ_SYNC_STAGES-1]};
    clr       = 3'b000;
    state_nxt = state;
    est_nxt   = est;
`ifdef EXC_TIMEOUT_EN
    terr_nxt  = terr;
`endif
    case (state)
      IDLE: begin
        if (|(pend | src)) begin
          state_nxt = REQ;
          est_nxt   = prio(pend | src);
        end
      end
      REQ: begin
        if (ex.ExcAck) begin
          clr       = code_bit(est);
          state_nxt = HANDLER;
        end
`ifdef EXC_TIMEOUT_EN
        else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          clr       = code_bit(est);
          state_nxt = IDLE;
          terr_nxt  = 1'b1;
        end
`endif
      end
      HANDLER: begin
        if (ex.ERet) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a source firing on the clearing edge keeps its bit
    pend_nxt = (pend & ~clr) | src;
`ifdef EXC_TIMEOUT_EN
    cnt_nxt  = (state == REQ) ? cnt + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pend  <= '0;
      est   <= '0;
      exc_q <= 1'b0;
      hnd_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      est   <= est_nxt;
      exc_q <= (state_nxt == REQ);
      hnd_q <= (state_nxt == HANDLER);
    end
  end

`ifdef EXC_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      terr <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      terr <= terr_nxt;
    end
  end
  assign timeout_err = terr;
`endif

  assign ex.Exc        = exc_q;
  assign ex.EStatus    = est;
  assign ex.in_handler = hnd_q;

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Directed bench for exc_request_ctrl; outputs sampled 1ns after each rising edge.
module tb_exc_request_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       irq = 1'b0, inv_opcode = 1'b0, dm_access = 1'b0;
  logic [2:0] dm_addr_lo = 3'b000;
`ifdef EXC_TIMEOUT_EN
  logic       timeout_err;
`endif
  int errors = 0;
  int checks = 0;

  exc_request_ctrl_if ex();

  exc_request_ctrl #(.IRQ_SYNC_STAGES(2), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .irq(irq), .inv_opcode(inv_opcode),
    .dm_access(dm_access), .dm_addr_lo(dm_addr_lo),
`ifdef EXC_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .ex(ex.master)
  );

  always #5 clk = ~clk;

  // {Exc, EStatus, in_handler}
  function automatic logic [5:0] st();
    return {ex.Exc, ex.EStatus, ex.in_handler};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; irq = 0; inv_opcode = 0; dm_access = 0; dm_addr_lo = 0;
    ex.ExcAck = 0; ex.ERet = 0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ex.ExcAck = 0; ex.ERet = 0;
    tick();
    checks++; if (st() !== 6'b0_0000_0) begin errors++; $display("FAIL reset_hold: got %b want 000000", st()); end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (st() !== 6'b0_0000_0) begin errors++; $display("FAIL reset_idle c%0d: got %b want 000000", i, st()); end
    end
  endtask

  task automatic test_inv();
    inv_opcode = 1; tick(); inv_opcode = 0;                       // now cycle "6"
    for (int i = 6; i <= 8; i++) begin
      checks++; if (st() !== 6'b1_0010_0) begin errors++; $display("FAIL inv_req c%0d: got %b want 100100", i, st()); end
      if (i == 8) ex.ExcAck = 1;
      tick();
    end
    ex.ExcAck = 0;                                                // cycle 9
    for (int i = 9; i <= 12; i++) begin
      checks++; if (st() !== 6'b0_0010_1) begin errors++; $display("FAIL inv_hnd c%0d: got %b want 000101", i, st()); end
      if (i == 12) ex.ERet = 1;
      tick();
    end
    ex.ERet = 0;                                                  // cycle 13
    checks++; if (st() !== 6'b0_0010_0) begin errors++; $display("FAIL inv_done: got %b want 000100", st()); end
    tick();
    checks++; if (ex.Exc !== 1'b0) begin errors++; $display("FAIL inv_quiet: got %b want 0", ex.Exc); end
  endtask

  task automatic test_irq();
    irq = 1; tick();                                              // cycle 4
    checks++; if (ex.Exc !== 1'b0) begin errors++; $display("FAIL irq_sync4: got %b want 0", ex.Exc); end
    tick();
    checks++; if (ex.Exc !== 1'b0) begin errors++; $display("FAIL irq_sync5: got %b want 0", ex.Exc); end
    tick();                                                       // cycle 6
    checks++; if (st() !== 6'b1_0001_0) begin errors++; $display("FAIL irq_req: got %b want 100010", st()); end
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    checks++; if (st() !== 6'b0_0001_1) begin errors++; $display("FAIL irq_hnd: got %b want 000011", st()); end
    ex.ERet = 1; tick(); ex.ERet = 0;
    checks++; if (st() !== 6'b0_0001_0) begin errors++; $display("FAIL irq_idle: got %b want 000010", st()); end
    tick();
    checks++; if (st() !== 6'b1_0001_0) begin errors++; $display("FAIL irq_repend: got %b want 100010", st()); end
    irq = 0; tick(); tick();                                      // let the sync chain drain before ack
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    ex.ERet = 1; tick(); ex.ERet = 0;
    tick(); tick();
    checks++; if (st() !== 6'b0_0001_0) begin errors++; $display("FAIL irq_drained: got %b want 000010", st()); end
  endtask

  task automatic test_priority();
    inv_opcode = 1; dm_access = 1; dm_addr_lo = 3'b100; tick();
    inv_opcode = 0; dm_access = 0; dm_addr_lo = 0;
    checks++; if (st() !== 6'b1_0011_0) begin errors++; $display("FAIL prio_first: got %b want 100110", st()); end
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    checks++; if (st() !== 6'b0_0011_1) begin errors++; $display("FAIL prio_hnd: got %b want 000111", st()); end
    ex.ERet = 1; tick(); ex.ERet = 0;
    checks++; if (st() !== 6'b0_0011_0) begin errors++; $display("FAIL prio_idle: got %b want 000110", st()); end
    tick();
    checks++; if (st() !== 6'b1_0010_0) begin errors++; $display("FAIL prio_second: got %b want 100100", st()); end
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    ex.ERet = 1; tick(); ex.ERet = 0;
    tick();
    checks++; if (ex.Exc !== 1'b0) begin errors++; $display("FAIL prio_quiet: got %b want 0", ex.Exc); end
  endtask

  task automatic test_req_hold();
    inv_opcode = 1; tick(); inv_opcode = 0;
    dm_access = 1; dm_addr_lo = 3'b001; tick(); dm_access = 0; dm_addr_lo = 0;
    checks++; if (st() !== 6'b1_0010_0) begin errors++; $display("FAIL hold_code: got %b want 100100", st()); end
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    ex.ERet = 1; tick(); ex.ERet = 0;
    tick();
    checks++; if (st() !== 6'b1_0011_0) begin errors++; $display("FAIL hold_late_mis: got %b want 100110", st()); end
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    ex.ERet = 1; tick(); ex.ERet = 0;
    tick();
  endtask

  task automatic test_inv_in_handler();
    inv_opcode = 1; tick(); inv_opcode = 0;
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    inv_opcode = 1; tick(); inv_opcode = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (st() !== 6'b0_0010_1) begin errors++; $display("FAIL hinv_mask c%0d: got %b want 000101", i, st()); end
      tick();
    end
    ex.ERet = 1; tick(); ex.ERet = 0;
    checks++; if (st() !== 6'b0_0010_0) begin errors++; $display("FAIL hinv_idle: got %b want 000100", st()); end
    tick();
    checks++; if (st() !== 6'b1_0010_0) begin errors++; $display("FAIL hinv_req: got %b want 100100", st()); end
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    ex.ERet = 1; tick(); ex.ERet = 0;
    tick();
  endtask

  task automatic test_ignored();
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    checks++; if (st() !== 6'b0_0010_0) begin errors++; $display("FAIL ign_ack_idle: got %b want 000100", st()); end
    ex.ERet = 1; tick(); ex.ERet = 0;
    checks++; if (st() !== 6'b0_0010_0) begin errors++; $display("FAIL ign_eret_idle: got %b want 000100", st()); end
    inv_opcode = 1; tick(); inv_opcode = 0;
    ex.ERet = 1; tick(); ex.ERet = 0;
    checks++; if (st() !== 6'b1_0010_0) begin errors++; $display("FAIL ign_eret_req: got %b want 100100", st()); end
    ex.ERet = 1; ex.ExcAck = 1; tick(); ex.ERet = 0; ex.ExcAck = 0;
    checks++; if (st() !== 6'b0_0010_1) begin errors++; $display("FAIL ign_both: got %b want 000101", st()); end
    ex.ERet = 1; tick(); ex.ERet = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    inv_opcode = 1; tick(); inv_opcode = 0;
    dm_access = 1; dm_addr_lo = 3'b010;                           // mis pending while in REQ
    #2 reset = 1'b0; #1;
    checks++; if (st() !== 6'b0_0000_0) begin errors++; $display("FAIL rst_async: got %b want 000000", st()); end
    dm_access = 0; dm_addr_lo = 0;
    tick(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (st() !== 6'b0_0000_0) begin errors++; $display("FAIL rst_lost c%0d: got %b want 000000", i, st()); end
    end
  endtask

`ifdef EXC_TIMEOUT_EN
  task automatic test_timeout();
    do_reset(); tick();
    inv_opcode = 1; tick(); inv_opcode = 0;
    for (int i = 1; i <= 16; i++) begin
      checks++; if (ex.Exc !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_req c%0d: got exc=%b err=%b want 1 0", i, ex.Exc, timeout_err); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ex.Exc !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_expired c%0d: got exc=%b err=%b want 0 1", i, ex.Exc, timeout_err); end
      tick();
    end
    do_reset(); tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_reset: got %b want 0", timeout_err); end
    inv_opcode = 1; tick(); inv_opcode = 0;
    for (int i = 1; i < 16; i++) tick();
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    checks++; if (st() !== 6'b0_0010_1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_ack_wins: got %b err=%b want 000101 0", st(), timeout_err); end
    ex.ERet = 1; tick(); ex.ERet = 0;
  endtask
`else
  task automatic test_no_timeout();
    inv_opcode = 1; tick(); inv_opcode = 0;
    for (int i = 0; i < 40; i++) tick();
    checks++; if (st() !== 6'b1_0010_0) begin errors++; $display("FAIL wait_forever: got %b want 100100", st()); end
    ex.ExcAck = 1; tick(); ex.ExcAck = 0;
    ex.ERet = 1; tick(); ex.ERet = 0;
  endtask
`endif

  initial begin
    test_reset();
    tick(); tick();
    test_inv();
    test_irq();
    test_priority();
    test_req_hold();
    test_inv_in_handler();
    test_ignored();
    test_reset_mid();
`ifdef EXC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
